alu16_sequencer: RTL and testbench

- Control stage directly upstream of the 16-bit ALU (`alu` instance with `alu_width=16`). It executes one Z80 16-bit arithmetic instruction per request: ADD HL,rr; ADC HL,rr; SBC HL,rr; INC rr; DEC rr.
- The ALU has no carry input, so ADC and SBC run as two ALU passes.
- The block drives the ALU operands and opcode, registers `alu_out` and `alu_status`, merges the Z80 flags, and presents the result with a one-cycle done pulse to register-file writeback.

---
 rtl/alu16_sequencer.sv | 138 +++++++++++++
 tb/tb_alu16_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu16_sequencer.sv
// alu16_sequencer: Z80 16-bit ADD/ADC/SBC/INC/DEC sequencer in front of a carry-less ALU; define ALU16_UNDOC_XY_EN to take Y/X from result[13]/[11]
module alu16_sequencer #(
  parameter int         DATA_WIDTH = 16,
  parameter logic [4:0] OP_ADD     = 5'b00000,
  parameter logic [4:0] OP_SUB     = 5'b00001,
  parameter logic [4:0] OP_INC     = 5'b01100,
  parameter logic [4:0] OP_DEC     = 5'b01101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [7:0]            flags_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [7:0]            flags_out,
  output logic                  flags_we,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_opcode,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [7:0]            alu_status
);
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, tmp_q, tmp_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d, result_q, result_d;
  logic [7:0]            f_q, f_d, st1_q, st1_d, st2_q, st2_d, flags_q, flags_d, merged;
  logic [4:0]            opc_q, opc_d;
  logic                  done_q, done_d, we_q, we_d, two_pass, illegal;
  logic [DATA_WIDTH-1:0] res;
  logic [1:0]            xy;
  assign two_pass = (op_q == 3'd1) || (op_q == 3'd2);
  assign illegal  = op_q > 3'd4;
  assign res      = illegal ? a_q : tmp_q;
`ifdef ALU16_UNDOC_XY_EN
  assign xy = {res[13], res[11]};
`else
  assign xy = {f_q[5], f_q[3]};
`endif
  // ADC/SBC split the carry-in into a second pass, so carry, half-carry and overflow are ORed across passes
  assign merged = (op_q == 3'd0) ? {f_q[7], f_q[6], xy[1], st1_q[4], xy[0], f_q[2], 1'b0, st1_q[0]} :
                  two_pass ? {st2_q[7], st2_q[6], xy[1], st1_q[4] | st2_q[4], xy[0],
                              st1_q[2] | st2_q[2], op_q[1], st1_q[0] | st2_q[0]} : f_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    f_d      = f_q;
    tmp_d    = tmp_q;
    st1_d    = st1_q;
    st2_d    = st2_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    opc_d    = opc_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = PASS1;
        op_d    = op;
        a_d     = op_a;
        f_d     = flags_in;
        alu_a_d = op_a;
        alu_b_d = (op <= 3'd2) ? op_b : '0;
        opc_d   = (op == 3'd2) ? OP_SUB : (op == 3'd3) ? OP_INC : (op == 3'd4) ? OP_DEC : OP_ADD;
      end
      PASS1: begin
        tmp_d   = alu_out;
        st1_d   = alu_status;
        state_d = two_pass ? PASS2 : DONE;
        if (two_pass) begin
          alu_a_d = alu_out;
          alu_b_d = {{(DATA_WIDTH-1){1'b0}}, f_q[0]};
          opc_d   = (op_q == 3'd2) ? OP_SUB : OP_ADD;
        end
      end
      PASS2: begin
        tmp_d   = alu_out;
        st2_d   = alu_status;
        state_d = DONE;
      end
      DONE: begin
        state_d  = IDLE;
        done_d   = 1'b1;
        we_d     = op_q <= 3'd2;
        result_d = res;
        flags_d  = merged;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      f_q      <= '0;
      tmp_q    <= '0;
      st1_q    <= '0;
      st2_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      opc_q    <= OP_ADD;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      f_q      <= f_d;
      tmp_q    <= tmp_d;
      st1_q    <= st1_d;
      st2_q    <= st2_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      opc_q    <= opc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      we_q     <= we_d;
    end
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign result     = result_q;
  assign flags_out  = flags_q;
  assign flags_we   = we_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = opc_q;
endmodule

// File: tb/tb_alu16_sequencer.sv
// tb_alu16_sequencer: directed table, corner sequences and random ops against an arithmetic reference model
module tb_alu16_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] op_a = '0, op_b = '0;
  logic [7:0]  flags_in = '0;
  logic        busy, done, flags_we;
  logic [15:0] result, alu_a, alu_b, alu_out;
  logic [7:0]  flags_out, alu_status;
  logic [4:0]  alu_opcode;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  alu16_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flags_in(flags_in), .busy(busy), .done(done), .result(result), .flags_out(flags_out),
    .flags_we(flags_we), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_status(alu_status)
  );
  // Stand-in for the external 16-bit ALU
  logic [16:0] s17;
  logic [12:0] s13;
  logic        av, an;
  always_comb begin
    s17 = '0;
    s13 = '0;
    av  = 1'b0;
    an  = 1'b0;
    case (alu_opcode)
      5'b00000: begin
        s17 = {1'b0, alu_a} + {1'b0, alu_b};
        s13 = {1'b0, alu_a[11:0]} + {1'b0, alu_b[11:0]};
        av  = (alu_a[15] == alu_b[15]) && (s17[15] != alu_a[15]);
      end
      5'b00001: begin
        s17 = {1'b0, alu_a} - {1'b0, alu_b};
        s13 = {1'b0, alu_a[11:0]} - {1'b0, alu_b[11:0]};
        av  = (alu_a[15] != alu_b[15]) && (s17[15] != alu_a[15]);
        an  = 1'b1;
      end
      5'b01100: s17 = {1'b0, alu_a + 16'd1};
      5'b01101: s17 = {1'b0, alu_a - 16'd1};
      default:  s17 = 17'h0dead;
    endcase
    alu_out    = s17[15:0];
    alu_status = {s17[15], s17[15:0] == 16'd0, s17[13], s13[12], s17[11], av, an, s17[16]};
  end
  function automatic void model(input logic [2:0] o, input logic [15:0] a, b, input logic [7:0] f,
                                output logic [15:0] r, output logic [7:0] fo, output logic we, output int lat);
    int ua, ub, c, sa, sb, t, s1;
    logic h, cy, v;
    logic [15:0] r1;
    ua = int'(a); ub = int'(b); c = int'(f[0]);
    sa = int'($signed(a)); sb = int'($signed(b));
    we = o <= 3'd2;
    lat = (o == 3'd1 || o == 3'd2) ? 3 : 2;
    h = 1'b0; cy = 1'b0; v = 1'b0; fo = f; r = a; t = 0;
    case (o)
      3'd0: begin t = ua + ub; r = 16'(t); cy = t > 65535; h = (ua % 4096 + ub % 4096) > 4095; end
      3'd1: begin
        t = ua + ub + c; r = 16'(t); cy = t > 65535; h = (ua % 4096 + ub % 4096 + c) > 4095;
        r1 = 16'(ua + ub); s1 = int'($signed(r1));
        v = (sa + sb > 32767) || (sa + sb < -32768) || (s1 + c > 32767);
      end
      3'd2: begin
        t = ua - ub - c; r = 16'(t); cy = t < 0; h = (ua % 4096 - ub % 4096 - c) < 0;
        r1 = 16'(ua - ub); s1 = int'($signed(r1));
        v = (sa - sb > 32767) || (sa - sb < -32768) || (s1 - c < -32768);
      end
      3'd3: r = 16'(ua + 1);
      3'd4: r = 16'(ua - 1);
      default: r = a;
    endcase
    if (o == 3'd0) fo = {f[7], f[6], f[5], h, f[3], f[2], 1'b0, cy};
    else if (we) fo = {r[15], r == 16'd0, f[5], h, f[3], v, o == 3'd2, cy};
`ifdef ALU16_UNDOC_XY_EN
    if (we) begin fo[5] = r[13]; fo[3] = r[11]; end
`endif
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, b, input logic [7:0] f,
                        output logic [15:0] r, output logic [7:0] fo, output logic we, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b; flags_in = f;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); op_a = 16'($urandom); op_b = 16'($urandom); flags_in = 8'($urandom);
    chk("busy after accept", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) lat = k;
    end
    r = result; fo = flags_out; we = flags_we;
  endtask
  task automatic do_vec(input string nm, input logic [2:0] o, input logic [15:0] a, b, input logic [7:0] f,
                        input logic [15:0] er, input logic [7:0] ef, input logic ewe, input int elat);
    logic [15:0] r;
    logic [7:0] fo;
    logic we;
    int lat;
    run_op(o, a, b, f, r, fo, we, lat);
    chk({nm, " latency"}, 32'(lat), 32'(elat));
    chk({nm, " result"}, 32'(r), 32'(er));
    chk({nm, " flags_out"}, 32'(fo), 32'(ef));
    chk({nm, " flags_we"}, 32'(we), 32'(ewe));
  endtask
  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a, b;
    logic [7:0]  f;
    logic [15:0] r;
    logic [7:0]  fo;
    logic        we;
    logic [3:0]  lat;
  } vec_t;
  vec_t vt[9];
  initial begin
    logic [15:0] er, ra, rb;
    logic [7:0]  ef, rf;
    logic        ewe;
    int elat, dones, seen;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] er, ra, rb;
    logic [7:0]  ef, rf;
    logic [2:0]  ro;
    logic        ewe;
    int elat, dones, seen;
    vt[0] = '{3'd0, 16'habcd, 16'h0101, 8'hc4, 16'hacce, 8'hc4, 1'b1, 4'd2};
    vt[1] = '{3'd1, 16'hffff, 16'h0000, 8'h01, 16'h0000, 8'h51, 1'b1, 4'd3};
    vt[2] = '{3'd2, 16'habcd, 16'habcc, 8'h01, 16'h0000, 8'h42, 1'b1, 4'd3};
    vt[3] = '{3'd2, 16'habcd, 16'habcc, 8'h00, 16'h0001, 8'h02, 1'b1, 4'd3};
    vt[4] = '{3'd3, 16'hffff, 16'h1234, 8'ha5, 16'h0000, 8'ha5, 1'b0, 4'd2};
    vt[5] = '{3'd4, 16'h0000, 16'h1234, 8'h3c, 16'hffff, 8'h3c, 1'b0, 4'd2};
    vt[6] = '{3'd5, 16'h1234, 16'h5678, 8'h81, 16'h1234, 8'h81, 1'b0, 4'd2};
    vt[7] = '{3'd0, 16'h8000, 16'h8000, 8'h00, 16'h0000, 8'h01, 1'b1, 4'd2};
    vt[8] = '{3'd1, 16'h7fff, 16'h0000, 8'h01, 16'h8000, 8'h94, 1'b1, 4'd3};
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {busy, done, flags_we, alu_opcode, flags_out, result}, 32'd0);
    chk("reset operands", {alu_a, alu_b}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ef = vt[i].fo;
`ifdef ALU16_UNDOC_XY_EN
      if (vt[i].we) begin ef[5] = vt[i].r[13]; ef[3] = vt[i].r[11]; end
`endif
      do_vec($sformatf("table[%0d]", i), vt[i].op, vt[i].a, vt[i].b, vt[i].f, vt[i].r, ef, vt[i].we, int'(vt[i].lat));
    end
    // start held high through a busy ADC: one done, then immediate re-accept
    @(negedge clk);
    start = 1'b1; op = 3'd1; op_a = 16'h1234; op_b = 16'h4321; flags_in = 8'h01;
    @(posedge clk);
    dones = 0; seen = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      dones += int'(done);
      if (done) seen = k;
    end
    chk("held start done count", 32'(dones), 32'd1);
    chk("held start done cycle", 32'(seen), 32'd3);
    chk("held start result", 32'(result), 32'h5556);
    @(posedge clk);
    #1;
    chk("reaccept busy/done", {busy, done}, 32'b10);
    start = 1'b0;
    seen = 0;
    for (int k = 1; k <= 6 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = k;
    end
    chk("second op latency", 32'(seen), 32'd3);
    // reset while in PASS2
    @(negedge clk);
    start = 1'b1; op = 3'd2; op_a = 16'h9999; op_b = 16'h1111; flags_in = 8'hff;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midop reset outputs", {busy, done, flags_we, alu_opcode, flags_out, result}, 32'd0);
    chk("midop reset operands", {alu_a, alu_b}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      dones += int'(done);
    end
    chk("no done after reset", 32'(dones), 32'd0);
    model(3'd0, 16'h0f00, 16'h0100, 8'h00, er, ef, ewe, elat);
    do_vec("add after reset", 3'd0, 16'h0f00, 16'h0100, 8'h00, er, ef, ewe, elat);
    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: ra = 16'h0000; 1: ra = 16'hffff; 2: ra = 16'h7fff; 3: ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      rf = 8'($urandom);
      model(ro, ra, rb, rf, er, ef, ewe, elat);
      do_vec($sformatf("rnd op%0d %h,%h f%h", ro, ra, rb, rf), ro, ra, rb, rf, er, ef, ewe, elat);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
